taus_urng_multi: RTL and testbench
==================================

# taus_urng_multi

Parametrised multi-channel combined Tausworthe (taus88) uniform random number generator, the next generation of the single-channel Tausworthe block that feeds the AWGN front end (Box-Muller / log-sqrt stages). It keeps N_CH independent three-component 32-bit states. Each channel can be seeded at runtime through a seed port. Samples leave through a valid/ready handshake, so downstream stalls never drop or repeat a sample.

## Interface
- N_CH, 4: number of independent generator channels (1..16).
- OUT_W, 32: bits per channel output, taken from the MSBs of the 32-bit combined word (1..32).
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  run request; generation is allowed while high.
- seed_valid  in  1  seed word present.
- seed_ready  out  1  seed accepted when seed_valid && seed_ready.
- seed_ch  in  $clog2(N_CH) (min 1)  target channel index.
- seed_t0, seed_t1, seed_t2  in  32 each  component seeds.
- out_valid  out  1  t_out holds a fresh sample set.
- out_ready  in  1  consumer accepts t_out.
- t_out  out  N_CH*OUT_W  channel c occupies bits [c*OUT_W +: OUT_W].

## Operation
- Per-channel taus88 step, with s0/s1/s2 corresponding to t0/t1/t2:
  - b=((s0<<13)^s0)>>19; s0'=((s0&32'hFFFFFFFE)<<12)^b
  - b=((s1<<2)^s1)>>25; s1'=((s1&32'hFFFFFFF8)<<4)^b
  - b=((s2<<3)^s2)>>11; s2'=((s2&32'hFFFFFFF0)<<17)^b
  - word = s0'^s1'^s2'. All arithmetic is 32-bit with logical shifts; bits shifted out are discarded.
- A generate event updates the state of every channel and registers word[31:32-OUT_W] into t_out in the same edge.
- FSM states:
  - IDLE:
    - out_valid=0, seed_ready=1.
    - Goes to RUN when en=1.
  - RUN:
    - A generate event happens every cycle; out_valid=1.
    - If out_valid && !out_ready: no generate event, go to HOLD.
    - If en=0 and the current sample is consumed (or none is pending): go to IDLE.
  - HOLD:
    - State and t_out are frozen; out_valid=1.
    - When out_ready=1, the sample is consumed. Go to RUN, generating on that same edge, if en=1; otherwise go to IDLE.
- seed_ready=1 only in IDLE. Seeds are never applied mid-stream.
- Seed acceptance in IDLE with en=1 on the same cycle: the seed is written first. The FSM enters RUN, and the first sample comes from the seeded state.
- An out-of-range seed_ch (>= N_CH) is accepted and ignored.
- Reset values:
  - FSM=IDLE, out_valid=0, seed_ready=1, t_out=0.
  - Channel c default state: t0=32'hC0FFEE00+c, t1=32'hDEADBEE0+(c<<4), t2=32'hFACE0000+(c<<5).
- Reset asserted mid-stream: all state returns to the defaults immediately. The sample held in t_out is lost.

## Timing
- Latency: en rises at edge k (IDLE -> RUN). The first generate event is at edge k+1, where out_valid rises. After that, one sample set per cycle while out_ready=1.
- A seed accepted at edge k is visible in state at k+1. It is reflected in t_out at the first generate event after that.
- Throughput is one sample set per clock with no bubbles under continuous out_ready.
- out_valid never drops without a handshake while a sample is pending.

## Configuration
- TAUS_SEED_CHECK_EN:
  - Defined: accepted seeds are sanitised before storage, so that degenerate all-zero or low seeds can never lock a channel.
    - t0<2 -> t0|32'h2
    - t1<8 -> t1|32'h8
    - t2<16 -> t2|32'h10
  - Undefined: seeds are stored verbatim; a degenerate seed is allowed to lock the channel.

## Structure
- Package taus_pkg holds:
  - the default seed constants and per-channel offsets;
  - the mask constants (32'hFFFFFFFE, 32'hFFFFFFF8, 32'hFFFFFFF0);
  - the FSM state enum (IDLE, RUN, HOLD).
- Sub-module taus_step: combinational single-channel step (state in -> next state plus 32-bit word), instantiated N_CH times by generate.
- The top level holds the FSM, the state registers, seed decode/sanitise and the output register.

## Test plan
- Reset, then en=1 with out_ready=1 for 20 cycles -> out_valid rises one edge after en. Every channel word matches the golden C taus88 model run from the default seeds; no gaps.
- Seed ch1 with (12345, 12345, 12345) in IDLE, then run -> ch1 matches the golden model from that seed; the other channels remain on the default sequence.
- out_ready held 0 for 5 cycles mid-stream -> t_out and out_valid=1 are frozen. The next sample after release is the successor of the held sample, with no skip or repeat.
- seed_valid while in RUN -> seed_ready=0 and the seed is not applied. Drop en and reseed in IDLE -> the seed is accepted.
- Seed all zeros on ch0:
  - without TAUS_SEED_CHECK_EN, the ch0 output stays 0 forever;
  - with it, the stored state is (2, 8, 16) and the output is nonzero and matches the golden model.
- Assert rst during HOLD -> out_valid=0 and t_out=0 immediately. After release and en, the sequence restarts from the default seeds.

Source files
------------

// File: rtl/taus_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | taus_pkg : shared constants, types and reset-state helper         |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package taus_pkg;

  localparam logic [31:0] C_T0_SEED = 32'hC0FFEE00;
  localparam logic [31:0] C_T1_SEED = 32'hDEADBEE0;
  localparam logic [31:0] C_T2_SEED = 32'hFACE0000;

  // Per-channel offsets applied to the default seeds as (c << shift)
  localparam int unsigned C_T0_OFS_SH = 0;
  localparam int unsigned C_T1_OFS_SH = 4;
  localparam int unsigned C_T2_OFS_SH = 5;

  localparam logic [31:0] C_MASK0 = 32'hFFFFFFFE;
  localparam logic [31:0] C_MASK1 = 32'hFFFFFFF8;
  localparam logic [31:0] C_MASK2 = 32'hFFFFFFF0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } taus_fsm_e;

  typedef struct packed {
    logic [31:0] t0;
    logic [31:0] t1;
    logic [31:0] t2;
  } taus_state_t;

  function automatic taus_state_t default_state(input int unsigned ch);
    taus_state_t s;
    s.t0 = C_T0_SEED + (ch << C_T0_OFS_SH);
    s.t1 = C_T1_SEED + (ch << C_T1_OFS_SH);
    s.t2 = C_T2_SEED + (ch << C_T2_OFS_SH);
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/taus_step.sv
`default_nettype none
// +------------------------------------------------------------------+
// | taus_step : combinational single-channel taus88 step              |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module taus_step
  import taus_pkg::*;
(
  input  taus_state_t i_state,
  output taus_state_t o_state,
  output logic [31:0] o_word
);

  logic [31:0] w_b0;
  logic [31:0] w_b1;
  logic [31:0] w_b2;

  always_comb begin
    w_b0       = ((i_state.t0 << 13) ^ i_state.t0) >> 19;
    w_b1       = ((i_state.t1 << 2)  ^ i_state.t1) >> 25;
    w_b2       = ((i_state.t2 << 3)  ^ i_state.t2) >> 11;
    o_state.t0 = ((i_state.t0 & C_MASK0) << 12) ^ w_b0;
    o_state.t1 = ((i_state.t1 & C_MASK1) << 4)  ^ w_b1;
    o_state.t2 = ((i_state.t2 & C_MASK2) << 17) ^ w_b2;
    o_word     = o_state.t0 ^ o_state.t1 ^ o_state.t2;
  end

endmodule
`default_nettype wire

// File: rtl/taus_urng_multi.sv
`default_nettype none
// +------------------------------------------------------------------+
// | taus_urng_multi : N_CH-channel taus88 URNG, valid/ready output    |
// | Optional seed sanitising: define TAUS_SEED_CHECK_EN               |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module taus_urng_multi
  import taus_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int OUT_W = 32,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  seed_valid,
  output logic                  seed_ready,
  input  logic [CH_W-1:0]       seed_ch,
  input  logic [31:0]           seed_t0,
  input  logic [31:0]           seed_t1,
  input  logic [31:0]           seed_t2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_CH*OUT_W-1:0] t_out
);

  taus_fsm_e             state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic                  seed_ready_q, seed_ready_d;
  logic [N_CH*OUT_W-1:0] t_out_q, t_out_d;
  taus_state_t           ch_q [N_CH];
  taus_state_t           ch_d [N_CH];

  taus_state_t           w_next [N_CH];
  logic [31:0]           w_word [N_CH];
  logic [N_CH*OUT_W-1:0] w_out;
  taus_state_t           w_seed;
  logic                  w_gen;
  logic                  w_seed_acc;

  assign w_seed_acc = seed_valid && seed_ready_q;

  always_comb begin
    w_seed.t0 = seed_t0;
    w_seed.t1 = seed_t1;
    w_seed.t2 = seed_t2;
`ifdef TAUS_SEED_CHECK_EN
    // Low seeds would leave a component with no live bits after masking
    if (seed_t0 < 32'd2)  w_seed.t0 = seed_t0 | 32'h2;
    if (seed_t1 < 32'd8)  w_seed.t1 = seed_t1 | 32'h8;
    if (seed_t2 < 32'd16) w_seed.t2 = seed_t2 | 32'h10;
`endif
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    taus_step u_step (
      .i_state (ch_q[c]),
      .o_state (w_next[c]),
      .o_word  (w_word[c])
    );

    assign w_out[c*OUT_W +: OUT_W] = w_word[c][31 -: OUT_W];

    // Generation and seeding are exclusive: seeds only land in IDLE
    assign ch_d[c] = w_gen ? w_next[c] :
                     (w_seed_acc && (32'(seed_ch) == c)) ? w_seed : ch_q[c];
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    w_gen       = 1'b0;
    unique case (state_q)
      IDLE: begin
        out_valid_d = 1'b0;
        if (en) state_d = RUN;
      end
      RUN: begin
        if (out_valid_q && !out_ready) begin
          state_d = HOLD;
        end else if (!en) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else begin
          w_gen       = 1'b1;
          out_valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (en) begin
            state_d = RUN;
            w_gen   = 1'b1;
          end else begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    seed_ready_d = (state_d == IDLE);
    t_out_d      = w_gen ? w_out : t_out_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      seed_ready_q <= 1'b1;
      t_out_q      <= '0;
      for (int c = 0; c < N_CH; c++) ch_q[c] <= default_state(c);
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      seed_ready_q <= seed_ready_d;
      t_out_q      <= t_out_d;
      for (int c = 0; c < N_CH; c++) ch_q[c] <= ch_d[c];
    end
  end

  assign out_valid  = out_valid_q;
  assign seed_ready = seed_ready_q;
  assign t_out      = t_out_q;

endmodule
`default_nettype wire

// File: tb/tb_taus_urng_multi.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_taus_urng_multi : directed bench against a taus88 C-style model|
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_taus_urng_multi;

  localparam int N_CH  = 4;
  localparam int OUT_W = 32;
  localparam int TW    = N_CH * OUT_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          seed_valid;
  logic          seed_ready;
  logic [1:0]    seed_ch;
  logic [31:0]   seed_t0, seed_t1, seed_t2;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] t_out;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0]   m0 [N_CH];
  logic [31:0]   m1 [N_CH];
  logic [31:0]   m2 [N_CH];
  logic [TW-1:0] exp_out;

  always #5 clk = ~clk;

  taus_urng_multi #(.N_CH(N_CH), .OUT_W(OUT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .seed_ch    (seed_ch),
    .seed_t0    (seed_t0),
    .seed_t1    (seed_t1),
    .seed_t2    (seed_t2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .t_out      (t_out)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_default();
    for (int c = 0; c < N_CH; c++) begin
      m0[c] = 32'hC0FFEE00 + 32'(c);
      m1[c] = 32'hDEADBEE0 + (32'(c) << 4);
      m2[c] = 32'hFACE0000 + (32'(c) << 5);
    end
  endtask

  task automatic model_seed(input int c, input logic [31:0] a, input logic [31:0] b, input logic [31:0] d);
`ifdef TAUS_SEED_CHECK_EN
    if (a < 2)  a = a | 32'h2;
    if (b < 8)  b = b | 32'h8;
    if (d < 16) d = d | 32'h10;
`endif
    m0[c] = a;
    m1[c] = b;
    m2[c] = d;
  endtask

  // Reference taus88 step, written as in the C reference generator
  task automatic model_adv();
    logic [31:0] b;
    logic [31:0] w;
    for (int c = 0; c < N_CH; c++) begin
      b     = ((m0[c] << 13) ^ m0[c]) >> 19;
      m0[c] = ((m0[c] & 32'd4294967294) << 12) ^ b;
      b     = ((m1[c] << 2) ^ m1[c]) >> 25;
      m1[c] = ((m1[c] & 32'd4294967288) << 4) ^ b;
      b     = ((m2[c] << 3) ^ m2[c]) >> 11;
      m2[c] = ((m2[c] & 32'd4294967280) << 17) ^ b;
      w     = m0[c] ^ m1[c] ^ m2[c];
      exp_out[c*OUT_W +: OUT_W] = w[31 -: OUT_W];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step();
      model_adv();
      chk({tag, "_valid"}, 128'(out_valid), 128'(1'b1));
      chk(tag, 128'(t_out), 128'(exp_out));
    end
  endtask

  initial begin
    rst        = 1'b0;
    en         = 1'b0;
    seed_valid = 1'b0;
    seed_ch    = '0;
    seed_t0    = '0;
    seed_t1    = '0;
    seed_t2    = '0;
    out_ready  = 1'b0;
    exp_out    = '0;
    model_default();

    repeat (2) step();
    chk("rst_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_sready", 128'(seed_ready), 128'(1'b1));
    chk("rst_tout", 128'(t_out), 128'(0));

    rst = 1'b1;
    step();
    en        = 1'b1;
    out_ready = 1'b1;
    step();
    chk("lat_valid", 128'(out_valid), 128'(1'b0));
    run_check(20, "dflt");

    // Stall for 5 cycles, then expect the direct successor
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", 128'(out_valid), 128'(1'b1));
      chk("hold_tout", 128'(t_out), 128'(exp_out));
    end
    out_ready = 1'b1;
    run_check(3, "release");

    // Seed offered mid-stream must be refused
    seed_valid = 1'b1;
    seed_ch    = 2'd2;
    seed_t0    = 32'h1234_5678;
    seed_t1    = 32'h9ABC_DEF0;
    seed_t2    = 32'h0F0F_0F0F;
    chk("run_sready", 128'(seed_ready), 128'(1'b0));
    run_check(2, "run_seed");
    seed_valid = 1'b0;
    en         = 1'b0;
    step();
    chk("idle_valid", 128'(out_valid), 128'(1'b0));
    chk("idle_sready", 128'(seed_ready), 128'(1'b1));

    seed_valid = 1'b1;
    seed_ch    = 2'd1;
    seed_t0    = 32'd12345;
    seed_t1    = 32'd12345;
    seed_t2    = 32'd12345;
    step();
    model_seed(1, 32'd12345, 32'd12345, 32'd12345);
    seed_valid = 1'b0;
    en         = 1'b1;
    step();
    chk("seed1_lat", 128'(out_valid), 128'(1'b0));
    run_check(6, "seed1");

    // Zero seed on ch0 together with en in the same IDLE cycle
    en = 1'b0;
    step();
    seed_valid = 1'b1;
    seed_ch    = 2'd0;
    seed_t0    = '0;
    seed_t1    = '0;
    seed_t2    = '0;
    en         = 1'b1;
    step();
    model_seed(0, 32'd0, 32'd0, 32'd0);
    seed_valid = 1'b0;
    chk("zero_lat", 128'(out_valid), 128'(1'b0));
    run_check(6, "zero");
`ifdef TAUS_SEED_CHECK_EN
    chk("ch0_nonzero", 128'(t_out[OUT_W-1:0] != '0), 128'(1'b1));
`else
    chk("ch0_locked", 128'(t_out[OUT_W-1:0]), 128'(0));
`endif

    // Asynchronous reset while holding a sample
    out_ready = 1'b0;
    step();
    step();
    chk("hold2_tout", 128'(t_out), 128'(exp_out));
    rst = 1'b0;
    #1;
    chk("arst_valid", 128'(out_valid), 128'(1'b0));
    chk("arst_tout", 128'(t_out), 128'(0));
    chk("arst_sready", 128'(seed_ready), 128'(1'b1));
    step();
    rst       = 1'b1;
    out_ready = 1'b1;
    model_default();
    step();
    chk("rstart_lat", 128'(out_valid), 128'(1'b0));
    run_check(5, "restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
